// File: rtl/wptr_full_ctrl_if.sv
// rtl/wptr_full_ctrl_if.sv - write-side client/memory/read-pointer bundle for the FIFO write controller
interface wptr_full_ctrl_if #(
    parameter int ADDR_W = 3
);
    // Client request, read-domain pointer and overflow clear.
    logic              winc;
    logic [ADDR_W:0]   wq2_rptr;
    logic              wovf_clr;

    // Controller outputs: memory address, Gray pointer and status.
    logic [ADDR_W-1:0] waddr;
    logic [ADDR_W:0]   wptr;
    logic              wfull;
    logic              walmost_full;
    logic [ADDR_W:0]   wlevel;
    logic              woverflow;

    // Drives the requests and observes the status.
    modport master (
        output winc,
        output wq2_rptr,
        output wovf_clr,
        input  waddr,
        input  wptr,
        input  wfull,
        input  walmost_full,
        input  wlevel,
        input  woverflow
    );

    // The write controller itself.
    modport slave (
        input  winc,
        input  wq2_rptr,
        input  wovf_clr,
        output waddr,
        output wptr,
        output wfull,
        output walmost_full,
        output wlevel,
        output woverflow
    );
endinterface

// File: rtl/wptr_full_ctrl.sv
// rtl/wptr_full_ctrl.sv - async FIFO write-side pointer, full/almost-full, level and overflow controller
module wptr_full_ctrl #(
    parameter int DEPTH       = 8,
    parameter int ADDR_W      = $clog2(DEPTH),
    parameter int SYNC_STAGES = 2,
    parameter int AF_THRESH   = DEPTH - 2
) (
    input  logic               wclk,
    input  logic               wrst,
    wptr_full_ctrl_if.slave    wbus
);

    // Threshold sized to the pointer width so the compare is unsigned and width-matched.
    localparam logic [ADDR_W:0] AF_T = AF_THRESH[ADDR_W:0];

    // Pointer state.
    logic [ADDR_W:0] wbin;
    logic [ADDR_W:0] wgray;
    logic [ADDR_W:0] wbin_next;
    logic [ADDR_W:0] wgray_next;
    logic            push;

    // Read-pointer synchroniser and its decoded form.
    logic [ADDR_W:0] sync_q [SYNC_STAGES];
    logic [ADDR_W:0] rq_s;
    logic [ADDR_W:0] rbin;

    // Status, computed from the next pointer so a push is reflected at its own edge.
    logic [ADDR_W:0] full_pattern;
    logic [ADDR_W:0] level_next;
    logic            full_next;
    logic            af_next;

    // Registered status flags.
    logic            wfull_q;
    logic            walmost_q;
    logic [ADDR_W:0] wlevel_q;
    logic            wovf_q;

    // A write is only accepted while not full; this is also the memory write enable.
    assign push = wbus.winc & ~wfull_q;

    // Next binary pointer wraps naturally at 2*DEPTH; Gray follows from it.
    always_comb begin
        wbin_next  = wbin + {{ADDR_W{1'b0}}, push};
        wgray_next = (wbin_next >> 1) ^ wbin_next;
    end

    // Binary and Gray write pointers; the Gray copy is what crosses to the read side.
    always_ff @(posedge wclk) begin
        if (wrst) begin
            wbin  <= '0;
            wgray <= '0;
        end else begin
            wbin  <= wbin_next;
            wgray <= wgray_next;
        end
    end

    // Plain flop chain on the asynchronous read pointer; no logic between stages.
    always_ff @(posedge wclk) begin
        if (wrst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= wbus.wq2_rptr;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign rq_s = sync_q[SYNC_STAGES-1];

    // Gray-to-binary by XOR prefix from the MSB downwards.
    always_comb begin
        rbin         = '0;
        rbin[ADDR_W] = rq_s[ADDR_W];
        for (int i = ADDR_W - 1; i >= 0; i--) begin
            rbin[i] = rbin[i+1] ^ rq_s[i];
        end
    end

    // Full when the write pointer is one lap ahead: top two Gray bits inverted, rest equal.
    // Level uses the lagging read pointer, so it can only over-report occupancy.
    always_comb begin
        full_pattern = {~rq_s[ADDR_W:ADDR_W-1], rq_s[ADDR_W-2:0]};
        full_next    = (wgray_next == full_pattern);
        level_next   = wbin_next - rbin;
        af_next      = (level_next >= AF_T);
    end

    // Registered full, almost-full and level so downstream sees clean flop outputs.
    always_ff @(posedge wclk) begin
        if (wrst) begin
            wfull_q   <= 1'b0;
            walmost_q <= 1'b0;
            wlevel_q  <= '0;
        end else begin
            wfull_q   <= full_next;
            walmost_q <= af_next;
            wlevel_q  <= level_next;
        end
    end

    // Sticky overflow: a blocked write sets it, and a set in the same cycle beats a clear.
    always_ff @(posedge wclk) begin
        if (wrst) begin
            wovf_q <= 1'b0;
        end else if (wbus.winc & wfull_q) begin
            wovf_q <= 1'b1;
        end else if (wbus.wovf_clr) begin
            wovf_q <= 1'b0;
        end
    end

    assign wbus.waddr        = wbin[ADDR_W-1:0];
    assign wbus.wptr         = wgray;
    assign wbus.wfull        = wfull_q;
    assign wbus.walmost_full = walmost_q;
    assign wbus.wlevel       = wlevel_q;
    assign wbus.woverflow    = wovf_q;

endmodule
